// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-resolution path.
package bp_pkg;
  localparam int BP_XLEN    = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic               taken;
    logic [BP_XLEN-1:0] pc;
    logic [BP_XLEN-1:0] target;
  } bq_entry_t;
endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of in-flight predicted branches; wrap-bit pointers, sync clear.
module branch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/branch_resolver.sv
// Compares predicted branches against execute outcomes; emits predictor
// training strobes, mispredict flush/redirect and a saturating mispredict count.
module branch_resolver
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             upd_valid,
  output logic             upd_outcome,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             underflow_err
);
  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t head, wr_entry;
  logic   full, empty, push, resolve, mispred;

  assign pred_ready = !full;
  assign push       = pred_valid && !full;
  assign resolve    = res_valid && !empty;
  assign mispred    = resolve && ((res_taken != head.taken) ||
                                  (res_taken && (res_target != head.target)));

  always_comb begin
    wr_entry        = '0;
    wr_entry.taken  = pred_taken;
    wr_entry.pc     = pred_pc;
    wr_entry.target = pred_target;
  end

  // A mispredict clears the queue, which also drops any same-cycle push.
  branch_queue #(.DEPTH(DEPTH), .W($bits(entry_t))) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mispred),
    .push  (push),
    .pop   (resolve),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid     <= 1'b0;
      upd_outcome   <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      mispred_cnt   <= '0;
      underflow_err <= 1'b0;
    end else begin
      upd_valid <= resolve;
      flush     <= mispred;
      if (resolve) upd_outcome <= res_taken;
      if (mispred) begin
        redirect_pc <= res_taken ? res_target : head.pc + XLEN'(INSN_BYTES);
        if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
      end
      if (res_valid && empty) underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized + directed bench for branch_resolver against a queue-based model.
module tb_branch_resolver;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;  // narrow counter so saturation is reachable quickly
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pred_valid, pred_ready, pred_taken;
  logic [XLEN-1:0]  pred_pc, pred_target;
  logic             res_valid, res_taken;
  logic [XLEN-1:0]  res_target;
  logic             upd_valid, upd_outcome, flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispred_cnt;
  logic             underflow_err;

  branch_resolver #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_outcome(upd_outcome), .flush(flush),
    .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  bq_entry_t   mq[$];
  int          m_cnt;
  logic        m_upd, m_out, m_flush, m_uf;
  logic [31:0] m_redir;

  int total = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_upd = 0; m_out = 0; m_flush = 0; m_uf = 0; m_redir = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".upd_valid"}, 64'(upd_valid), 64'(m_upd));
    check({tag, ".flush"}, 64'(flush), 64'(m_flush));
    check({tag, ".cnt"}, 64'(mispred_cnt), 64'(m_cnt));
    check({tag, ".underflow"}, 64'(underflow_err), 64'(m_uf));
    if (m_upd)   check({tag, ".outcome"}, 64'(upd_outcome), 64'(m_out));
    if (m_flush) check({tag, ".redirect"}, 64'(redirect_pc), 64'(m_redir));
  endtask

  // One clock: drive, check pred_ready, advance model, check registered outputs.
  task automatic step(input string tag,
                      input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    bq_entry_t h, e;
    logic acc, mis;
    pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    check({tag, ".ready"}, 64'(pred_ready), 64'(mq.size() < DEPTH));
    acc = pv && (mq.size() < DEPTH);
    e.taken = pt; e.pc = ppc; e.target = ptg;
    m_upd = 0; m_flush = 0;
    if (rv) begin
      if (mq.size() == 0) m_uf = 1;
      else begin
        h = mq[0];
        mis = (rt != h.taken) || (rt && rtg != h.target);
        m_upd = 1; m_out = rt;
        if (mis) begin
          m_flush = 1;
          m_redir = rt ? rtg : h.pc + 32'd4;
          if (m_cnt < CMAX) m_cnt++;
          mq.delete();
          acc = 0;
        end else void'(mq.pop_front());
      end
    end
    if (acc) mq.push_back(e);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] r_tg;
    logic        r_t, pv, rv;
    bq_entry_t   h;

    pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    model_reset();
    rst_n = 0;
    #12;
    check("rst.ready", 64'(pred_ready), 64'd1);
    check_outputs("rst");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // 1: correct taken prediction
    step("t1.push", 1, 1, 32'h100, 32'h200, 0, 0, 0);
    step("t1.res",  0, 0, 0, 0, 1, 1, 32'h200);
    // 2: direction mispredicts
    step("t2.push", 1, 0, 32'h100, 32'h0, 0, 0, 0);
    step("t2.res",  0, 0, 0, 0, 1, 1, 32'h180);
    step("t2.push2", 1, 1, 32'h300, 32'h400, 0, 0, 0);
    step("t2.res2",  0, 0, 0, 0, 1, 0, 32'h0);
    // 3: target mismatch
    step("t3.push", 1, 1, 32'h10, 32'h40, 0, 0, 0);
    step("t3.res",  0, 0, 0, 0, 1, 1, 32'h44);
    // fall-through wraps modulo 2^32
    step("wrap.push", 1, 1, 32'hFFFF_FFFC, 32'h80, 0, 0, 0);
    step("wrap.res",  0, 0, 0, 0, 1, 0, 32'h0);
    // 4: fill, overfill, mispredict with push, underflow
    for (int i = 0; i < DEPTH; i++)
      step("t4.fill", 1, 0, 32'h1000 + 32'(i * 16), 32'h0, 0, 0, 0);
    step("t4.over", 1, 0, 32'h2000, 32'h0, 0, 0, 0);
    step("t4.mis",  1, 0, 32'h3000, 32'h0, 1, 1, 32'h5000);
    step("t4.uf",   0, 0, 0, 0, 1, 0, 32'h0);
    idle("t4.idle");
    // 5: wrap-around with simultaneous push/correct-resolve
    for (int i = 0; i <= 10; i++) begin
      pv = (i < 10);
      rv = (i > 0);
      if (rv) begin h = mq[0]; r_t = h.taken; r_tg = h.target; end
      else begin r_t = 0; r_tg = 0; end
      step("t5", pv, 1'(i % 2), 32'h4000 + 32'(i * 8), 32'h6000 + 32'(i * 4), rv, r_t, r_tg);
    end
    // randomized traffic; mostly-correct resolves keep the queue busy
    for (int i = 0; i < 300; i++) begin
      pv = 1'($urandom_range(0, 3) != 0);
      rv = 1'($urandom_range(0, 2) != 0);
      if (mq.size() != 0 && $urandom_range(0, 4) != 0) begin
        h = mq[0]; r_t = h.taken; r_tg = h.taken ? h.target : 32'($urandom);
      end else begin
        r_t = 1'($urandom); r_tg = 32'($urandom_range(0, 3)) << 4;
      end
      step("rnd", pv, 1'($urandom), 32'($urandom) & ~32'h3,
           32'($urandom_range(0, 3)) << 4, rv, r_t, r_tg);
    end
    // 6: saturate the mispredict counter, then one past
    while (m_cnt < CMAX + 1 && total < 20000) begin
      idle("t6.drain");
      step("t6.push", 1, 0, 32'h700, 32'h0, 0, 0, 0);
      step("t6.res",  0, 0, 0, 0, 1, 1, 32'h900);
      if (m_cnt == CMAX) begin
        step("t6.push", 1, 0, 32'h700, 32'h0, 0, 0, 0);
        step("t6.hold", 0, 0, 0, 0, 1, 1, 32'h900);
        break;
      end
    end
    check("t6.sat", 64'(mispred_cnt), 64'(CMAX));
    // asynchronous reset mid-stream
    pred_valid = 1; pred_taken = 1; pred_pc = 32'h10; pred_target = 32'h20;
    res_valid = 1; res_taken = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    model_reset();
    check("arst.ready", 64'(pred_ready), 64'd1);
    check("arst.redirect", 64'(redirect_pc), 64'd0);
    check("arst.outcome", 64'(upd_outcome), 64'd0);
    check_outputs("arst");
    pred_valid = 0; res_valid = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    step("post.res", 0, 0, 0, 0, 1, 0, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
